// File: rtl/fixed_mac_pkg.sv
// -----------------------------------------------------------------------------
// fixed_mac_pkg
// Shared types and constants for the fixed-point MAC operand driver.
//   drv_state_t    : 2-bit FSM state encoding (IDLE, SEND, WAIT_RES, DONE)
//   TIMEOUT_LIMIT  : terminal count of the optional WAIT_RES timeout counter
//                    (only used when FIXED_MAC_DRIVER_TIMEOUT_EN is defined)
// -----------------------------------------------------------------------------
package fixed_mac_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND     = 2'd1,
      WAIT_RES = 2'd2,
      DONE     = 2'd3
   } drv_state_t;

   localparam logic [15:0] TIMEOUT_LIMIT = 16'hFFFF;

endpackage

// File: rtl/fixed_mac_drv_buf.sv
// -----------------------------------------------------------------------------
// fixed_mac_drv_buf
// Operand vector buffer: DEPTH entries, each holding one A and one B element.
// One write port writes both halves of an entry; two independent registered
// read ports (A and B) let the two stream channels stall independently.
// Entries never written since the last reset read back as zero.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   wr_en/wr_addr         : write strobe and entry index
//   wr_a, wr_b            : A and B element written to the entry
//   a_rd_en/a_rd_addr     : A read request; a_rd_data updates on the next edge
//   b_rd_en/b_rd_addr     : B read request; b_rd_data updates on the next edge
//   a_rd_data, b_rd_data  : registered read data, held while no read is issued
// -----------------------------------------------------------------------------
module fixed_mac_drv_buf #(
   parameter int WA    = 12,
   parameter int WB    = 8,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [WA-1:0] wr_a,
   input  logic [WB-1:0] wr_b,
   input  logic          a_rd_en,
   input  logic [AW-1:0] a_rd_addr,
   output logic [WA-1:0] a_rd_data,
   input  logic          b_rd_en,
   input  logic [AW-1:0] b_rd_addr,
   output logic [WB-1:0] b_rd_data
);

   logic [WA-1:0]    mem_a [DEPTH];
   logic [WB-1:0]    mem_b [DEPTH];
   logic [DEPTH-1:0] written;

   // NOTE: the storage arrays have no reset so they can map onto plain
   // register-file cells; the small written mask is reset instead and
   // forces never-written entries to read as zero.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_a[wr_addr] <= wr_a;
         mem_b[wr_addr] <= wr_b;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         written   <= '0;
         a_rd_data <= '0;
         b_rd_data <= '0;
      end else begin
         if (wr_en)
            written[wr_addr] <= 1'b1;
         if (a_rd_en)
            a_rd_data <= written[a_rd_addr] ? mem_a[a_rd_addr] : '0;
         if (b_rd_en)
            b_rd_data <= written[b_rd_addr] ? mem_b[b_rd_addr] : '0;
      end
   end

endmodule

// File: rtl/fixed_mac_driver.sv
// -----------------------------------------------------------------------------
// fixed_mac_driver
// Streams two fixed-point operand vectors (A: Q WI1.WF1, B: Q WI2.WF2) out of
// a local buffer as independent valid/ready channels into a MAC, then waits
// for the MAC result (Q WIO.WFO) and latches it with its overflow/underflow
// flags.
//
// Ports
//   clk, reset                    : clock, synchronous active-high reset
//   ld_we, ld_addr, ld_a, ld_b    : buffer load port (accepted only when idle)
//   start, len                    : job request, element count 1..DEPTH
//   A_data/A_valid/A_ready/A_last : A operand stream
//   B_data/B_valid/B_ready/B_last : B operand stream
//   out_data/out_valid/out_ready  : MAC result handshake (out_last ignored)
//   overflow, underflow           : MAC saturation flags returned with result
//   busy, done, result            : job status, one-cycle completion pulse,
//   res_ovf, res_unf, err           latched result/flags, error pulse
//
// Build option
//   FIXED_MAC_DRIVER_TIMEOUT_EN : when defined, WAIT_RES gives up after 65535
//   cycles without a result, pulses err and returns to IDLE without done.
// -----------------------------------------------------------------------------
module fixed_mac_driver
   import fixed_mac_pkg::*;
#(
   parameter int WI1   = 4,
   parameter int WF1   = 8,
   parameter int WI2   = 3,
   parameter int WF2   = 5,
   parameter int WIO   = 15,
   parameter int WFO   = 30,
   parameter int DEPTH = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           ld_we,
   input  logic [$clog2(DEPTH)-1:0]       ld_addr,
   input  logic [WI1+WF1-1:0]             ld_a,
   input  logic [WI2+WF2-1:0]             ld_b,
   input  logic                           start,
   input  logic [$clog2(DEPTH):0]         len,
   output logic signed [WI1+WF1-1:0]      A_data,
   output logic                           A_valid,
   input  logic                           A_ready,
   output logic                           A_last,
   output logic signed [WI2+WF2-1:0]      B_data,
   output logic                           B_valid,
   input  logic                           B_ready,
   output logic                           B_last,
   input  logic [WIO+WFO-1:0]             out_data,
   input  logic                           out_valid,
   output logic                           out_ready,
   input  logic                           out_last,
   input  logic                           overflow,
   input  logic                           underflow,
   output logic                           busy,
   output logic                           done,
   output logic [WIO+WFO-1:0]             result,
   output logic                           res_ovf,
   output logic                           res_unf,
   output logic                           err
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int WA = WI1 + WF1;
   localparam int WB = WI2 + WF2;
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

   drv_state_t    state;
   logic [PW-1:0] len_q;
   logic [PW-1:0] a_ptr, b_ptr;     // beats accepted so far on each channel
   logic [PW-1:0] a_next, b_next;   // pointer value after this cycle
   logic          a_free, b_free;   // output register may take a new beat
   logic          a_load, b_load;   // fetch the next element this cycle
   logic          len_ok;
   logic [WA-1:0] a_rd_data;
   logic [WB-1:0] b_rd_data;
   logic          buf_we;

`ifdef FIXED_MAC_DRIVER_TIMEOUT_EN
   logic [15:0]   to_cnt;
`endif

   // The MAC's frame marker carries no information this driver needs.
   logic unused_out_last;
   assign unused_out_last = out_last;

   assign len_ok = (len != '0) && (len <= DEPTH_P);
   assign buf_we = ld_we && (state == IDLE);

   // A pointer counts accepted beats; the element at a_next is prefetched
   // whenever the output register is empty or is being drained this cycle,
   // which gives one beat per cycle under continuous ready.
   assign a_next = a_ptr + PW'(A_valid && A_ready);
   assign b_next = b_ptr + PW'(B_valid && B_ready);
   assign a_free = !A_valid || A_ready;
   assign b_free = !B_valid || B_ready;
   assign a_load = (state == SEND) && a_free && (a_next < len_q);
   assign b_load = (state == SEND) && b_free && (b_next < len_q);

   assign A_data = a_rd_data;
   assign B_data = b_rd_data;

   fixed_mac_drv_buf #(
      .WA    (WA),
      .WB    (WB),
      .DEPTH (DEPTH)
   ) u_buf (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (buf_we),
      .wr_addr   (ld_addr),
      .wr_a      (ld_a),
      .wr_b      (ld_b),
      .a_rd_en   (a_load),
      .a_rd_addr (a_next[AW-1:0]),
      .a_rd_data (a_rd_data),
      .b_rd_en   (b_load),
      .b_rd_addr (b_next[AW-1:0]),
      .b_rd_data (b_rd_data)
   );

   // NOTE: every register here is assigned with <= so all of them sample the
   // same pre-edge values; the pulse outputs default low each cycle first.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         len_q     <= '0;
         a_ptr     <= '0;
         b_ptr     <= '0;
         A_valid   <= 1'b0;
         A_last    <= 1'b0;
         B_valid   <= 1'b0;
         B_last    <= 1'b0;
         out_ready <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         result    <= '0;
         res_ovf   <= 1'b0;
         res_unf   <= 1'b0;
`ifdef FIXED_MAC_DRIVER_TIMEOUT_EN
         to_cnt    <= '0;
`endif
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (len_ok) begin
                     state <= SEND;
                     busy  <= 1'b1;
                     len_q <= len;
                     a_ptr <= '0;
                     b_ptr <= '0;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end

            SEND: begin
               a_ptr <= a_next;
               b_ptr <= b_next;
               // A stalled beat keeps valid/last; otherwise the freshly
               // fetched element (if any) becomes the presented beat.
               if (a_free) begin
                  A_valid <= a_load;
                  A_last  <= a_load && (a_next == len_q - PW'(1));
               end
               if (b_free) begin
                  B_valid <= b_load;
                  B_last  <= b_load && (b_next == len_q - PW'(1));
               end
               if ((a_next == len_q) && (b_next == len_q)) begin
                  state     <= WAIT_RES;
                  out_ready <= 1'b1;
`ifdef FIXED_MAC_DRIVER_TIMEOUT_EN
                  to_cnt    <= '0;
`endif
               end
            end

            WAIT_RES: begin
               if (out_valid && out_ready) begin
                  result    <= out_data;
                  res_ovf   <= overflow;
                  res_unf   <= underflow;
                  out_ready <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end
`ifdef FIXED_MAC_DRIVER_TIMEOUT_EN
               else if (to_cnt == TIMEOUT_LIMIT - 16'd1) begin
                  // Counter reaches its limit together with the err pulse.
                  to_cnt    <= to_cnt + 16'd1;
                  out_ready <= 1'b0;
                  busy      <= 1'b0;
                  err       <= 1'b1;
                  state     <= IDLE;
               end else begin
                  to_cnt <= to_cnt + 16'd1;
               end
`endif
            end

            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fixed_mac_driver.sv
// -----------------------------------------------------------------------------
// tb_fixed_mac_driver
// Directed bench for fixed_mac_driver (default parameters). The stimulus
// thread loads the buffer, launches jobs and plays the MAC result side; for
// each job it queues the expected A/B beats (from its own model of the
// buffer) and the expected latched result. A monitor on the falling edge pops
// and compares on every A/B transfer and every done pulse, and checks that
// stalled beats stay put.
// -----------------------------------------------------------------------------
module tb_fixed_mac_driver;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        ld_we;
   logic [3:0]  ld_addr;
   logic [11:0] ld_a;
   logic [7:0]  ld_b;
   logic        start;
   logic [4:0]  len;
   logic [11:0] a_data;
   logic        a_valid, a_ready, a_last;
   logic [7:0]  b_data;
   logic        b_valid, b_ready, b_last;
   logic [44:0] out_data;
   logic        out_valid, out_ready, out_last, overflow, underflow;
   logic        busy, done, res_ovf, res_unf, err;
   logic [44:0] result;

   fixed_mac_driver dut (
      .clk       (clk),
      .reset     (reset),
      .ld_we     (ld_we),
      .ld_addr   (ld_addr),
      .ld_a      (ld_a),
      .ld_b      (ld_b),
      .start     (start),
      .len       (len),
      .A_data    (a_data),
      .A_valid   (a_valid),
      .A_ready   (a_ready),
      .A_last    (a_last),
      .B_data    (b_data),
      .B_valid   (b_valid),
      .B_ready   (b_ready),
      .B_last    (b_last),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .overflow  (overflow),
      .underflow (underflow),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .res_ovf   (res_ovf),
      .res_unf   (res_unf),
      .err       (err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Scoreboard queues: {last, data} per beat, {ovf, unf, data} per job.
   logic [12:0] qa [$];
   logic [8:0]  qb [$];
   logic [46:0] qr [$];

   // Model of buffer contents as loaded by this bench.
   logic [11:0] mem_a [DEPTH];
   logic [7:0]  mem_b [DEPTH];

   int a_xfer = 0, b_xfer = 0, done_cnt = 0, err_cnt = 0;
   int a_first_cyc, a_last_cyc, b_first_cyc, b_last_cyc;
   bit a_seen, b_seen;
   int job_start_cyc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc++;

   // ------------------------------------------------------------- monitor
   bit          a_stall, b_stall;
   logic [11:0] a_hold;
   logic [7:0]  b_hold;

   always @(negedge clk) begin
      logic [12:0] ea;
      logic [8:0]  eb;
      logic [46:0] er;
      if (reset) begin
         a_stall = 0;
         b_stall = 0;
      end else begin
         if (a_stall) begin
            check("a_stall_valid_held", 64'(a_valid), 64'(1));
            check("a_stall_data_held", 64'(a_data), 64'(a_hold));
         end
         if (b_stall) begin
            check("b_stall_valid_held", 64'(b_valid), 64'(1));
            check("b_stall_data_held", 64'(b_data), 64'(b_hold));
         end
         a_stall = a_valid && !a_ready;
         b_stall = b_valid && !b_ready;
         a_hold  = a_data;
         b_hold  = b_data;

         if (a_valid && a_ready) begin
            if (qa.size() == 0) check("a_unexpected_beat", 64'(a_valid), 64'(0));
            else begin
               ea = qa.pop_front();
               check("a_beat_data", 64'(a_data), 64'(ea[11:0]));
               check("a_beat_last", 64'(a_last), 64'(ea[12]));
               a_xfer++;
               if (!a_seen) begin a_first_cyc = cyc; a_seen = 1; end
               if (a_last) a_last_cyc = cyc;
            end
         end
         if (b_valid && b_ready) begin
            if (qb.size() == 0) check("b_unexpected_beat", 64'(b_valid), 64'(0));
            else begin
               eb = qb.pop_front();
               check("b_beat_data", 64'(b_data), 64'(eb[7:0]));
               check("b_beat_last", 64'(b_last), 64'(eb[8]));
               b_xfer++;
               if (!b_seen) begin b_first_cyc = cyc; b_seen = 1; end
               if (b_last) b_last_cyc = cyc;
            end
         end

         if (done) begin
            done_cnt++;
            if (qr.size() == 0) check("unexpected_done", 64'(done), 64'(0));
            else begin
               er = qr.pop_front();
               check("result", 64'(result), 64'(er[44:0]));
               check("res_ovf", 64'(res_ovf), 64'(er[46]));
               check("res_unf", 64'(res_unf), 64'(er[45]));
            end
         end
         if (err) err_cnt++;
      end
   end

   // ------------------------------------------------------------- stimulus
   task automatic do_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int idx, input logic [11:0] a, input logic [7:0] b);
      ld_we   = 1'b1;
      ld_addr = idx[3:0];
      ld_a    = a;
      ld_b    = b;
      do_cycle();
      ld_we   = 1'b0;
      mem_a[idx] = a;
      mem_b[idx] = b;
   endtask

   // mode 0: both readies high; mode 1: A_ready random, B_ready low 4 cycles.
   task automatic drive_job(input int n, input int mode, input logic [44:0] rdata,
                            input logic ovf, input logic unf, input int delay,
                            input bit junk_we);
      int  base_done;
      bit  seen;
      base_done = done_cnt;
      for (int i = 0; i < n; i++) begin
         qa.push_back({(i == n - 1), mem_a[i]});
         qb.push_back({(i == n - 1), mem_b[i]});
      end
      qr.push_back({ovf, unf, rdata});
      a_seen = 0;
      b_seen = 0;
      start   = 1'b1;
      len     = n[4:0];
      a_ready = 1'b1;
      b_ready = (mode == 0);
      job_start_cyc = cyc + 1;
      do_cycle();
      start = 1'b0;
      if (junk_we) begin
         // Load attempt while busy must not reach the buffer.
         ld_we   = 1'b1;
         ld_addr = 4'd0;
         ld_a    = 12'h7FF;
         ld_b    = 8'h7F;
      end
      seen = 0;
      for (int c = 1; c < 400 && !seen; c++) begin
         a_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         b_ready = (mode == 0) || (c >= 4);
         do_cycle();
         ld_we = 1'b0;
         seen  = out_ready;
      end
      check("out_ready_reached", 64'(seen), 64'(1));
      a_ready = 1'b1;
      b_ready = 1'b1;
      repeat (delay) do_cycle();
      out_valid = 1'b1;
      out_data  = rdata;
      overflow  = ovf;
      underflow = unf;
      out_last  = 1'b1;
      do_cycle();
      out_valid = 1'b0;
      out_last  = 1'b0;
      overflow  = 1'b0;
      underflow = 1'b0;
      for (int c = 0; c < 10 && done_cnt == base_done; c++) do_cycle();
      do_cycle();
      check("done_pulses_per_job", 64'(done_cnt - base_done), 64'(1));
      check("idle_after_job", 64'(busy), 64'(0));
      check("a_queue_drained", 64'(qa.size()), 64'(0));
      check("b_queue_drained", 64'(qb.size()), 64'(0));
   endtask

   task automatic bad_start(input logic [4:0] l);
      int base_err;
      base_err = err_cnt;
      start = 1'b1;
      len   = l;
      do_cycle();
      start = 1'b0;
      repeat (3) do_cycle();
      check("bad_len_err_pulse", 64'(err_cnt - base_err), 64'(1));
      check("bad_len_not_busy", 64'(busy), 64'(0));
      check("bad_len_no_a_valid", 64'(a_valid), 64'(0));
      check("bad_len_no_b_valid", 64'(b_valid), 64'(0));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int base;
      for (int i = 0; i < DEPTH; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
      reset = 1'b1;
      {ld_we, start, a_ready, b_ready, out_valid, out_last, overflow, underflow} = '0;
      ld_addr = '0; ld_a = '0; ld_b = '0; len = '0; out_data = '0;
      repeat (3) do_cycle();

      // Reset state
      check("rst_a_valid", 64'(a_valid), 64'(0));
      check("rst_b_valid", 64'(b_valid), 64'(0));
      check("rst_a_last", 64'(a_last), 64'(0));
      check("rst_b_last", 64'(b_last), 64'(0));
      check("rst_out_ready", 64'(out_ready), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_err", 64'(err), 64'(0));
      check("rst_result", 64'(result), 64'(0));
      check("rst_res_ovf", 64'(res_ovf), 64'(0));
      check("rst_res_unf", 64'(res_unf), 64'(0));
      reset = 1'b0;
      do_cycle();

      // A = {1.0, 2.0, -1.5} (Q4.8), B = {0.5, 0.5, 2.0} (Q3.5)
      load(0, 12'h100, 8'h10);
      load(1, 12'h200, 8'h10);
      load(2, 12'hE80, 8'h40);
      // Dot product -1.5 in Q15.30 = -3*2^29
      drive_job(3, 0, -45'sd1610612736, 1'b0, 1'b0, 5, 1'b1);
      check("a_first_beat_latency", 64'(a_first_cyc - job_start_cyc), 64'(1));
      check("a_beats_consecutive", 64'(a_last_cyc - a_first_cyc), 64'(2));
      check("b_first_beat_latency", 64'(b_first_cyc - job_start_cyc), 64'(1));
      check("b_beats_consecutive", 64'(b_last_cyc - b_first_cyc), 64'(2));

      // Entries 0..2 persist (entry 0 untouched by the busy-time load),
      // 3..6 new, 7 never written -> 0. Stalls on both channels; overflow.
      load(3, 12'h080, 8'h20);
      load(4, 12'hF00, 8'hF0);
      load(5, 12'h7FF, 8'h80);
      load(6, 12'h001, 8'h7F);
      drive_job(8, 1, 45'h0_1234_5678, 1'b1, 1'b0, 1, 1'b0);

      // Single-element job with underflow
      drive_job(1, 0, 45'd123, 1'b0, 1'b1, 2, 1'b0);

      // Illegal lengths
      bad_start(5'd0);
      bad_start(5'd17);

      // Result side pulse while idle is not captured
      base = done_cnt;
      out_valid = 1'b1; out_data = 45'd999; overflow = 1'b1;
      do_cycle();
      out_valid = 1'b0; overflow = 1'b0;
      do_cycle();
      check("idle_out_valid_result", 64'(result), 64'd123);
      check("idle_out_valid_ovf", 64'(res_ovf), 64'(0));
      check("idle_out_valid_unf", 64'(res_unf), 64'(1));
      check("idle_out_valid_no_done", 64'(done_cnt - base), 64'(0));

      // Reset after two beats of a 6-beat job
      for (int i = 0; i < 6; i++) begin
         qa.push_back({(i == 5), mem_a[i]});
         qb.push_back({(i == 5), mem_b[i]});
      end
      base = a_xfer;
      start = 1'b1; len = 5'd6; a_ready = 1'b1; b_ready = 1'b1;
      do_cycle();
      start = 1'b0;
      for (int c = 0; c < 50 && a_xfer < base + 2; c++) do_cycle();
      check("two_beats_before_reset", 64'(a_xfer - base), 64'(2));
      base = done_cnt;
      reset = 1'b1; a_ready = 1'b0; b_ready = 1'b0;
      do_cycle();
      check("abort_a_valid", 64'(a_valid), 64'(0));
      check("abort_b_valid", 64'(b_valid), 64'(0));
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_result", 64'(result), 64'(0));
      reset = 1'b0;
      qa.delete();
      qb.delete();
      repeat (4) do_cycle();
      check("abort_no_done", 64'(done_cnt - base), 64'(0));
      check("abort_stays_idle", 64'(a_valid | b_valid | busy), 64'(0));

      // Fresh job after reset: A = {3.0, 0.25}, B = {-1.0, 0.25}
      load(0, 12'h300, 8'hE0);
      load(1, 12'h040, 8'h08);
      drive_job(2, 0, 45'h1F_0000_0001, 1'b0, 1'b1, 3, 1'b0);

      check("final_result_queue_empty", 64'(qr.size()), 64'(0));
      check("total_done_pulses", 64'(done_cnt), 64'(4));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
